// File: rtl/multi_debouncer_pkg.sv
// ============================================================================
// Module      : multi_debouncer_pkg
// Description : Shared FSM state encoding, default timing and sizing helpers
//               for the multi-channel switch debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multi_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        PRESS_WAIT = 2'b01,
        PRESSED    = 2'b11,
        REL_WAIT   = 2'b10
    } db_state_t;

    // Defaults assume a 50 MHz clock: 30 ms debounce, 1 s long press
    localparam int C_DEF_N_CH        = 4;
    localparam int C_DEF_DB_CYCLES   = 1_500_000;
    localparam int C_DEF_SYNC_STAGES = 2;
    localparam int C_DEF_LONG_CYCLES = 50_000_000;
    localparam int C_MAX_N_CH        = 32;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multi_debouncer_channel.sv
// ============================================================================
// Module      : debounce_channel
// Description : One switch channel: synchroniser, debounce FSM, edge pulses.
//               Optional hold counter for long-press detection (LONG_PRESS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_channel
    import multi_debouncer_pkg::*;
#(
    parameter int DB_CYCLES   = C_DEF_DB_CYCLES,
    parameter int SYNC_STAGES = C_DEF_SYNC_STAGES
`ifdef LONG_PRESS_EN
    ,
    parameter int LONG_CYCLES = C_DEF_LONG_CYCLES
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic level,
    output logic press,
    output logic rel_pulse
`ifdef LONG_PRESS_EN
    ,
    output logic long_press
`endif
);

    localparam int             CW         = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0]  C_CNT_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    db_state_t              r_state;
    db_state_t              w_state_next;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_next;
    logic                   r_level;
    logic                   r_press;
    logic                   r_rel;
    logic                   w_level_next;
    logic                   w_press_next;
    logic                   w_rel_next;

    assign w_s = r_sync[SYNC_STAGES-1];

    // State register: synchroniser, FSM, counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_rel   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], sw};
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_level <= w_level_next;
            r_press <= w_press_next;
            r_rel   <= w_rel_next;
        end
    end

    // Next state: the counter only runs in the two wait states and every
    // exit at C_CNT_LAST leaves counting, so it can never wrap.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_s) begin
                    w_state_next = PRESS_WAIT;
                    w_cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_s) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_next = PRESSED;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!w_s) begin
                    w_state_next = REL_WAIT;
                    w_cnt_next   = '0;
                end
            end
            REL_WAIT: begin
                if (w_s) begin
                    w_state_next = PRESSED;
                    w_cnt_next   = '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so the registers line up
    // with the FSM transition edge.
    always_comb begin
        w_level_next = (w_state_next == PRESSED) || (w_state_next == REL_WAIT);
        w_press_next = (r_state == PRESS_WAIT) && (w_state_next == PRESSED);
        w_rel_next   = (r_state == REL_WAIT)   && (w_state_next == IDLE);
    end

    assign level     = r_level;
    assign press     = r_press;
    assign rel_pulse = r_rel;

`ifdef LONG_PRESS_EN
    localparam int            HW          = cnt_width(LONG_CYCLES + 1);
    localparam logic [HW-1:0] C_HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] C_HOLD_FIRE = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] r_hold;
    logic          r_long;
    logic          w_holding;

    assign w_holding = (r_state == PRESSED) || (r_state == REL_WAIT);

    // Cleared only on a real press, not on a rejected release glitch, so a
    // bouncy hold still yields a single long-press pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= w_holding && (r_hold == C_HOLD_FIRE);
            if (w_press_next) begin
                r_hold <= '0;
            end else if (w_holding && (r_hold != C_HOLD_MAX)) begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    assign long_press = r_long;
`endif

endmodule

`default_nettype wire

// File: rtl/multi_debouncer.sv
// ============================================================================
// Module      : multi_debouncer
// Description : N_CH independent switch debouncers with press/release pulses.
//               Define LONG_PRESS_EN to add the long_press output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_debouncer
    import multi_debouncer_pkg::*;
#(
    parameter int N_CH        = C_DEF_N_CH,
    parameter int DB_CYCLES   = C_DEF_DB_CYCLES,
    parameter int SYNC_STAGES = C_DEF_SYNC_STAGES,
    parameter int LONG_CYCLES = C_DEF_LONG_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] rel_pulse
`ifdef LONG_PRESS_EN
    ,
    output logic [N_CH-1:0] long_press
`endif
);

    if ((N_CH < 1) || (N_CH > C_MAX_N_CH)) begin : g_bad_n_ch
        $error("multi_debouncer: N_CH=%0d outside 1..%0d", N_CH, C_MAX_N_CH);
    end
    if (DB_CYCLES < 2) begin : g_bad_db_cycles
        $error("multi_debouncer: DB_CYCLES=%0d must be at least 2", DB_CYCLES);
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("multi_debouncer: SYNC_STAGES=%0d must be at least 2", SYNC_STAGES);
    end
    if (LONG_CYCLES < 2) begin : g_bad_long_cycles
        $error("multi_debouncer: LONG_CYCLES=%0d must be at least 2", LONG_CYCLES);
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DB_CYCLES   (DB_CYCLES),
            .SYNC_STAGES (SYNC_STAGES)
`ifdef LONG_PRESS_EN
            ,
            .LONG_CYCLES (LONG_CYCLES)
`endif
        ) u_channel (
            .clk        (clk),
            .rst        (rst),
            .sw         (sw[i]),
            .level      (level[i]),
            .press      (press[i]),
            .rel_pulse  (rel_pulse[i])
`ifdef LONG_PRESS_EN
            ,
            .long_press (long_press[i])
`endif
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_multi_debouncer.sv
// ============================================================================
// Module      : tb_multi_debouncer
// Description : Self-checking bench: run-length reference model compared every
//               cycle, directed latency/glitch/reset cases, random switching.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_debouncer;

    localparam int N_CH        = 4;
    localparam int DB_CYCLES   = 4;
    localparam int SYNC_STAGES = 2;
    localparam int LONG_CYCLES = 10;
    localparam int C_LAT       = SYNC_STAGES + DB_CYCLES + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] sw  = '0;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] rel_pulse;
`ifdef LONG_PRESS_EN
    logic [N_CH-1:0] long_press;
`endif

    multi_debouncer #(
        .N_CH        (N_CH),
        .DB_CYCLES   (DB_CYCLES),
        .SYNC_STAGES (SYNC_STAGES),
        .LONG_CYCLES (LONG_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .level      (level),
        .press      (press),
        .rel_pulse  (rel_pulse)
`ifdef LONG_PRESS_EN
        ,
        .long_press (long_press)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: s is sw delayed by SYNC_STAGES edges; a channel flips
    // once DB_CYCLES+1 consecutive samples disagree with its current level.
    int              m_k;
    logic [N_CH-1:0] sw_log [16];
    int              run_q   [N_CH];
    int              since_q [N_CH];
    int              run_d   [N_CH];
    int              since_d [N_CH];
    logic [N_CH-1:0] m_level, m_press, m_rel, m_long;
    logic [N_CH-1:0] lvl_d, prs_d, rel_d, lng_d, s_vec;

    always_comb begin
        s_vec = (m_k >= SYNC_STAGES) ? sw_log[(m_k - SYNC_STAGES) % 16] : '0;
        lvl_d = m_level;
        prs_d = '0;
        rel_d = '0;
        lng_d = '0;
        for (int c = 0; c < N_CH; c++) begin
            run_d[c]   = run_q[c];
            since_d[c] = since_q[c];
            if (m_level[c]) begin
                if (since_q[c] < LONG_CYCLES) since_d[c] = since_q[c] + 1;
                if (since_q[c] + 1 == LONG_CYCLES) lng_d[c] = 1'b1;
            end
            if (s_vec[c] != m_level[c]) begin
                run_d[c] = run_q[c] + 1;
                if (run_d[c] == DB_CYCLES + 1) begin
                    lvl_d[c] = s_vec[c];
                    prs_d[c] = s_vec[c];
                    rel_d[c] = !s_vec[c];
                    run_d[c] = 0;
                    if (s_vec[c]) since_d[c] = 0;
                end
            end else begin
                run_d[c] = 0;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k     <= 0;
            m_level <= '0;
            m_press <= '0;
            m_rel   <= '0;
            m_long  <= '0;
            for (int c = 0; c < N_CH; c++) begin
                run_q[c]   <= 0;
                since_q[c] <= 0;
            end
        end else begin
            sw_log[m_k % 16] <= sw;
            m_k     <= m_k + 1;
            m_level <= lvl_d;
            m_press <= prs_d;
            m_rel   <= rel_d;
            m_long  <= lng_d;
            for (int c = 0; c < N_CH; c++) begin
                run_q[c]   <= run_d[c];
                since_q[c] <= since_d[c];
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_level", 32'(level), 32'(m_level));
            chk("model_press", 32'(press), 32'(m_press));
            chk("model_rel_pulse", 32'(rel_pulse), 32'(m_rel));
`ifdef LONG_PRESS_EN
            chk("model_long_press", 32'(long_press), 32'(m_long));
`endif
        end
    end

    // sig: 0 press, 1 rel_pulse, 2 long_press; returns edges since call or -1
    task automatic wait_pulse(input int sig, input int ch, input int budget, output int at);
        int e0;
        logic b;
        e0 = cyc;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            b = 1'b0;
            if (sig == 0) b = press[ch];
            if (sig == 1) b = rel_pulse[ch];
`ifdef LONG_PRESS_EN
            if (sig == 2) b = long_press[ch];
`endif
            if (b) begin
                at = cyc - e0;
                break;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int at;
    logic [N_CH-1:0] seen;
    int long_at, long_cnt;
    int remain [N_CH];

    initial begin
        idle_cycles(3);
        cmp_en = 1'b1;
        chk("reset_level", 32'(level), 32'h0);
        chk("reset_press", 32'(press), 32'h0);
        chk("reset_rel_pulse", 32'(rel_pulse), 32'h0);
        rst = 1'b0;
        idle_cycles(4);

        // Single clean press on channel 0
        sw[0] = 1'b1;
        wait_pulse(0, 0, 40, at);
        chk("press0_latency", 32'(at), 32'(C_LAT));
        chk("press0_level", 32'(level), 32'h1);
        @(negedge clk);
        chk("press0_one_cycle", 32'(press), 32'h0);
        idle_cycles(3);

        // Short high burst on channel 1 is rejected
        sw[1] = 1'b1;
        idle_cycles(3);
        sw[1] = 1'b0;
        seen = '0;
        repeat (12) begin
            @(negedge clk);
            seen |= press;
        end
        chk("glitch_no_press1", 32'(seen[1]), 32'h0);
        chk("glitch_level1", 32'(level[1]), 32'h0);

        // Release glitch on channel 0, then a real release
        sw[0] = 1'b0;
        idle_cycles(2);
        sw[0] = 1'b1;
        seen = '0;
        repeat (12) begin
            @(negedge clk);
            seen |= rel_pulse;
        end
        chk("relglitch_no_rel0", 32'(seen[0]), 32'h0);
        chk("relglitch_level0", 32'(level[0]), 32'h1);
        sw[0] = 1'b0;
        wait_pulse(1, 0, 40, at);
        chk("rel0_latency", 32'(at), 32'(C_LAT));
        chk("rel0_level", 32'(level[0]), 32'h0);
        idle_cycles(4);

        // All channels together
        sw = '1;
        wait_pulse(0, 0, 40, at);
        chk("all_press_latency", 32'(at), 32'(C_LAT));
        chk("all_press_same_edge", 32'(press), 32'hF);
        idle_cycles(3);
        sw = '0;
        wait_pulse(1, 0, 40, at);
        chk("all_rel_latency", 32'(at), 32'(C_LAT));
        chk("all_rel_same_edge", 32'(rel_pulse), 32'hF);
        idle_cycles(4);

        // Reset in the middle of PRESS_WAIT on channel 3
        sw[3] = 1'b1;
        seen = '0;
        repeat (6) begin
            @(negedge clk);
            seen |= press;
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            seen |= press;
        end
        chk("rst_abort_no_press", 32'(seen), 32'h0);
        chk("rst_abort_level", 32'(level), 32'h0);
        rst = 1'b0;
        wait_pulse(0, 3, 40, at);
        chk("rst_redebounce_latency", 32'(at), 32'(C_LAT));
        sw[3] = 1'b0;
        idle_cycles(12);

`ifdef LONG_PRESS_EN
        // Long hold on channel 2: one long_press, then a release pulse
        sw[2] = 1'b1;
        wait_pulse(0, 2, 40, at);
        chk("long_press_edge", 32'(at), 32'(C_LAT));
        long_at  = -1;
        long_cnt = 0;
        for (int i = 1; i <= 23; i++) begin
            @(negedge clk);
            if (long_press[2]) begin
                long_cnt++;
                if (long_at < 0) long_at = i;
            end
        end
        chk("long_after_press", 32'(long_at), 32'(LONG_CYCLES));
        chk("long_once", 32'(long_cnt), 32'h1);
        sw[2] = 1'b0;
        wait_pulse(1, 2, 40, at);
        chk("long_rel_latency", 32'(at), 32'(C_LAT));
        idle_cycles(4);
`endif

        // Random switching: mostly short bounces, sometimes long holds
        for (int c = 0; c < N_CH; c++) remain[c] = 1;
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            for (int c = 0; c < N_CH; c++) begin
                remain[c]--;
                if (remain[c] <= 0) begin
                    sw[c] = ~sw[c];
                    if ($urandom_range(0, 3) == 0)
                        remain[c] = int'($urandom_range(8, 30));
                    else
                        remain[c] = int'($urandom_range(1, 7));
                end
            end
        end
        sw = '0;
        idle_cycles(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach its end (checks %0d, errors %0d)",
                 n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 Parameter N_CH, default 4: number of independent switch channels, range 1..32.
REQ-002 Parameter DB_CYCLES, default 1_500_000: stable-input cycles required to accept an edge (30 ms at 50 MHz), minimum 2.
REQ-003 Parameter SYNC_STAGES, default 2: input synchroniser depth, minimum 2.
REQ-004 Parameter LONG_CYCLES, default 50_000_000: held cycles for a long press (1 s at 50 MHz); used only with LONG_PRESS_EN.
REQ-005 clk  input  1  clock, all logic on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 sw  input  N_CH  raw asynchronous switch levels, active-high.
REQ-008 level  output  N_CH  debounced switch level per channel.
REQ-009 press  output  N_CH  one-cycle pulse per accepted rising edge.
REQ-010 rel_pulse  output  N_CH  one-cycle pulse per accepted falling edge.
REQ-011 long_press  output  N_CH  one-cycle pulse per long press; present only with LONG_PRESS_EN.

Function
REQ-012 Each channel SHALL be fully independent: own synchroniser, FSM and counter; no shared state between channels.
REQ-013 Each sw bit SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (s) feeds the FSM.
REQ-014 FSM states: IDLE, PRESS_WAIT, PRESSED, REL_WAIT.
REQ-015 IDLE: s=1 -> PRESS_WAIT with counter cleared; otherwise stay.
REQ-016 PRESS_WAIT: s=0 -> IDLE (glitch rejected, no pulse); counter = DB_CYCLES-1 with s=1 -> PRESSED; else counter+1.
REQ-017 PRESSED: s=0 -> REL_WAIT with counter cleared; otherwise stay.
REQ-018 REL_WAIT: s=1 -> PRESSED (glitch rejected, no pulse); counter = DB_CYCLES-1 with s=0 -> IDLE; else counter+1.
REQ-019 level SHALL be registered: 1 in PRESSED and REL_WAIT, 0 in IDLE and PRESS_WAIT.
REQ-020 press SHALL be registered and high for exactly the one cycle following the PRESS_WAIT->PRESSED transition; rel_pulse likewise for REL_WAIT->IDLE.
REQ-021 Latency: with sw stable, press (and the level rise) SHALL assert exactly SYNC_STAGES+DB_CYCLES+1 rising edges after the first edge sampling the new sw value; rel_pulse and the level fall symmetrically.
REQ-022 Counter width SHALL be clog2(DB_CYCLES); the counter SHALL never wrap, because every transition at DB_CYCLES-1 leaves the counting state.
REQ-023 Each accepted edge SHALL produce exactly one pulse; press and rel_pulse SHALL never be high together on one channel.

Reset
REQ-024 rst SHALL asynchronously force all synchroniser flops, counters and outputs to 0 and every FSM to IDLE.
REQ-025 rst asserted mid-debounce SHALL abort the channel with no pulse; after release, a held-high sw SHALL be re-debounced from IDLE with full latency.

Configuration
REQ-026 Macro LONG_PRESS_EN defined: each channel SHALL have a hold counter, cleared on entry to PRESSED, counting while in PRESSED or REL_WAIT, saturating at LONG_CYCLES.
REQ-027 With LONG_PRESS_EN: long_press SHALL pulse for one cycle when the hold count reaches LONG_CYCLES-1; at most once per press, with no auto-repeat, and rel_pulse still issues on release.
REQ-028 Macro undefined: long_press port and hold counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 Shared package multi_debouncer_pkg SHALL hold the FSM state typedef/encoding (IDLE=00, PRESS_WAIT=01, PRESSED=11, REL_WAIT=10) and the default-timing constants.
REQ-030 Per-channel logic SHALL be sub-module debounce_channel, replicated N_CH times by a generate loop in multi_debouncer.
REQ-031 Illegal parameters (DB_CYCLES<2, SYNC_STAGES<2, N_CH outside 1..32) SHALL cause an elaboration error.

Verification (N_CH=4, DB_CYCLES=4, SYNC_STAGES=2, LONG_CYCLES=10)
REQ-032 sw[0] 0->1 held -> press[0] one cycle at edge 7, level[0]=1 from edge 7; other channels stay 0.
REQ-033 sw[1] high for 3 cycles, then low -> no press[1], level[1] stays 0.
REQ-034 Channel pressed, sw low for 2 cycles then high again -> no rel_pulse, level stays 1; a sustained low later gives rel_pulse after 7 edges.
REQ-035 sw=4'b1111 simultaneously -> all four press bits pulse on the same edge; sw=0 later gives all four rel_pulse on the same edge.
REQ-036 rst pulsed at cycle 4 of PRESS_WAIT with sw held high -> no pulse; press occurs 7 edges after rst release.
REQ-037 LONG_PRESS_EN, sw[2] held 30 cycles -> press[2], then exactly one long_press[2] 10 cycles after press, then rel_pulse[2] on release.
